// File: rtl/sum_accumulator_if.sv
// Valid/ready sample-in / burst-result-out bundle for sum_accumulator.
// Optional macro SUM_ACC_PARITY_CHECK_EN adds the outParityErr signal.
interface sum_accumulator_if #(
  parameter int unsigned W     = 8,
  parameter int unsigned LEN_W = 4
);
  localparam int unsigned ACC_W = W + 1 + LEN_W;

  logic             inValid;
  logic             inReady;
  logic [W:0]       inSum;
  logic             inIsOdd;
  logic [LEN_W-1:0] burstLen;
  logic             outValid;
  logic             outReady;
  logic [ACC_W-1:0] outAcc;
  logic [LEN_W-1:0] outOddCnt;
`ifdef SUM_ACC_PARITY_CHECK_EN
  logic             outParityErr;

  modport master (
    output inValid, inSum, inIsOdd, burstLen, outReady,
    input  inReady, outValid, outAcc, outOddCnt, outParityErr
  );

  modport slave (
    input  inValid, inSum, inIsOdd, burstLen, outReady,
    output inReady, outValid, outAcc, outOddCnt, outParityErr
  );
`else
  modport master (
    output inValid, inSum, inIsOdd, burstLen, outReady,
    input  inReady, outValid, outAcc, outOddCnt
  );

  modport slave (
    input  inValid, inSum, inIsOdd, burstLen, outReady,
    output inReady, outValid, outAcc, outOddCnt
  );
`endif
endinterface

// File: rtl/sum_accumulator.sv
// Burst reducer behind the adder stage: sums a programmable number of
// (W+1)-bit samples, counts the odd ones, and hands the total downstream.
// Optional macro SUM_ACC_PARITY_CHECK_EN adds a sticky inIsOdd/inSum[0]
// mismatch flag on outParityErr.
module sum_accumulator #(
  parameter int unsigned W     = 8,
  parameter int unsigned LEN_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  sum_accumulator_if.slave bus
);
  localparam int unsigned ACC_W = W + 1 + LEN_W;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t           state, state_next;
  logic [ACC_W-1:0] acc, acc_next;
  logic [LEN_W-1:0] odd_cnt, odd_cnt_next;
  logic [LEN_W-1:0] cnt, cnt_next;
  logic [LEN_W-1:0] len, len_next;
  logic             in_ready;
  logic             out_valid;

  logic             accept_c;
  logic [LEN_W-1:0] first_len_c;

  assign accept_c    = bus.inValid & in_ready;
  // A zero burst length is treated as a single-sample burst.
  assign first_len_c = (bus.burstLen == '0) ? LEN_W'(1) : bus.burstLen;

  // Next-state and datapath update.
  always_comb begin
    state_next   = state;
    acc_next     = acc;
    odd_cnt_next = odd_cnt;
    cnt_next     = cnt;
    len_next     = len;
    case (state)
      IDLE: begin
        if (accept_c) begin
          len_next     = first_len_c;
          acc_next     = ACC_W'(bus.inSum);
          odd_cnt_next = LEN_W'(bus.inIsOdd);
          cnt_next     = LEN_W'(1);
          state_next   = (first_len_c == LEN_W'(1)) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (accept_c) begin
          acc_next     = acc + ACC_W'(bus.inSum);
          odd_cnt_next = odd_cnt + LEN_W'(bus.inIsOdd);
          cnt_next     = cnt + LEN_W'(1);
          if (cnt_next == len) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        if (bus.outReady) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, datapath and registered handshake decodes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      odd_cnt   <= '0;
      cnt       <= '0;
      len       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_next;
      acc       <= acc_next;
      odd_cnt   <= odd_cnt_next;
      cnt       <= cnt_next;
      len       <= len_next;
      in_ready  <= (state_next != DONE);
      out_valid <= (state_next == DONE);
    end
  end

  assign bus.inReady   = in_ready;
  assign bus.outValid  = out_valid;
  assign bus.outAcc    = acc;
  assign bus.outOddCnt = odd_cnt;

`ifdef SUM_ACC_PARITY_CHECK_EN
  logic parity_err;

  // Sticky flag: any accepted sample whose odd flag disagrees with its LSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_err <= 1'b0;
    end else if (accept_c && (bus.inIsOdd != bus.inSum[0])) begin
      parity_err <= 1'b1;
    end
  end

  assign bus.outParityErr = parity_err;
`endif
endmodule

// File: tb/tb_sum_accumulator.sv
// Scoreboard bench for sum_accumulator: driver pushes expected burst
// results, an independent monitor pops them on each result handshake.
`timescale 1ns/1ps
module tb_sum_accumulator;
  localparam int unsigned W     = 8;
  localparam int unsigned LEN_W = 4;

  typedef struct {
    longint acc;
    longint odd;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic hold_ready = 1'b0;
  logic rand_ready = 1'b0;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  longint last_acc_t = 0;
  bit   perr_model = 1'b0;

  sum_accumulator_if #(.W(W), .LEN_W(LEN_W)) bus ();

  sum_accumulator #(.W(W), .LEN_W(LEN_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Present one sample and wait (bounded) until it is accepted.
  task automatic send_sample(input int sum, input bit odd, input int blen);
    bit r;
    bit done;
    done = 1'b0;
    bus.inValid  = 1'b1;
    bus.inSum    = 9'(sum);
    bus.inIsOdd  = odd;
    bus.burstLen = 4'(blen);
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      r = bus.inReady;
      @(posedge clk);
      if (r) begin
        done = 1'b1;
        last_acc_t = longint'($time);
        if (odd != sum[0]) perr_model = 1'b1;
      end
    end
    #1;
    bus.inValid = 1'b0;
    if (!done) check("accept_timeout", 0, 1);
  endtask

  // Send a whole burst; expected result is plain sum and odd-flag count.
  task automatic run_burst(input int sums[$], input bit odds[$], input int blen, input bit gaps);
    exp_t e;
    int g;
    e.acc = 0;
    e.odd = 0;
    for (int i = 0; i < sums.size(); i++) begin
      if (gaps) begin
        g = $urandom_range(0, 2);
        if (g > 0) begin
          bus.inValid = 1'b0;
          repeat (g) @(posedge clk);
          #1;
        end
      end
      send_sample(sums[i], odds[i], (i == 0) ? blen : int'($urandom_range(0, 15)));
      e.acc += sums[i];
      e.odd += odds[i];
    end
    sb.push_back(e);
  endtask

  // Downstream ready generator.
  initial begin
    bus.outReady = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (hold_ready) bus.outReady = 1'b0;
      else if (rand_ready) bus.outReady = 1'($urandom_range(0, 1));
      else bus.outReady = 1'b1;
    end
  end

  // Monitor: handshake decodes, latency, stability, scoreboard compare.
  initial begin
    bit prev_valid;
    longint held_acc;
    longint held_odd;
    exp_t e;
    prev_valid = 1'b0;
    held_acc = 0;
    held_odd = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_valid = 1'b0;
      end else begin
        check("in_ready_vs_out_valid", bus.inReady, !bus.outValid);
        if (bus.outValid && !prev_valid) begin
          check("result_latency_ns", longint'($time) - last_acc_t, 5);
          held_acc = bus.outAcc;
          held_odd = bus.outOddCnt;
        end else if (bus.outValid) begin
          check("out_acc_stable", bus.outAcc, held_acc);
          check("out_odd_stable", bus.outOddCnt, held_odd);
        end
        if (bus.outValid && bus.outReady) begin
          if (sb.size() == 0) begin
            check("unexpected_result", 1, 0);
          end else begin
            e = sb.pop_front();
            check("out_acc", bus.outAcc, e.acc);
            check("out_odd_cnt", bus.outOddCnt, e.odd);
          end
        end
`ifdef SUM_ACC_PARITY_CHECK_EN
        check("parity_err", bus.outParityErr, perr_model);
`endif
        prev_valid = bus.outValid;
      end
    end
  end

  // Stimulus.
  initial begin
    int s[$];
    bit o[$];
    int n;
    int blen;
    bus.inValid  = 1'b0;
    bus.inSum    = '0;
    bus.inIsOdd  = 1'b0;
    bus.burstLen = '0;
    #12;
    check("rst_out_valid", bus.outValid, 0);
    check("rst_out_acc", bus.outAcc, 0);
    check("rst_out_odd", bus.outOddCnt, 0);
    check("rst_in_ready", bus.inReady, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    s = {2, 11, 4};  o = {0, 1, 0};  run_burst(s, o, 3, 0);
    s = {9};         o = {1};        run_burst(s, o, 0, 0);

    // Result held back while the next sample waits.
    hold_ready = 1'b1;
    s = {6, 4};      o = {0, 0};     run_burst(s, o, 2, 0);
    fork
      begin
        s = {7}; o = {1}; run_burst(s, o, 1, 0);
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        hold_ready = 1'b0;
      end
    join

    // Reset in the middle of a burst.
    send_sample(5, 1, 3);
    send_sample(5, 1, 3);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", bus.outValid, 0);
    check("midrst_out_acc", bus.outAcc, 0);
    check("midrst_out_odd", bus.outOddCnt, 0);
    check("midrst_in_ready", bus.inReady, 1);
    perr_model = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    s = {2};         o = {0};        run_burst(s, o, 1, 0);

    // Widest burst of largest samples.
    s = {};  o = {};
    for (int i = 0; i < 15; i++) begin
      s.push_back(511);
      o.push_back(1'b1);
    end
    run_burst(s, o, 15, 0);

    // Parity mismatch, then correct samples.
    s = {4};         o = {1};        run_burst(s, o, 1, 0);
    s = {3, 8};      o = {1, 0};     run_burst(s, o, 2, 0);

    // Randomized bursts with random gaps and downstream backpressure.
    rand_ready = 1'b1;
    for (int b = 0; b < 40; b++) begin
      n = $urandom_range(1, 15);
      blen = (n == 1 && $urandom_range(0, 1) == 1) ? 0 : n;
      s = {};  o = {};
      for (int i = 0; i < n; i++) begin
        s.push_back(int'($urandom_range(0, 511)));
        o.push_back(($urandom_range(0, 7) == 0) ? ~s[i][0] : s[i][0]);
      end
      run_burst(s, o, blen, 1);
    end
    rand_ready = 1'b0;

    for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
